// File: rtl/cci_mpf_prim_rr_fifo2_arb.sv
//
// cci_mpf_prim_rr_fifo2_arb
//
// Merges N_REQ independent producer channels onto one shared output stream.
// Every requester owns a private two-entry buffer. A round-robin scheduler
// picks one non-empty buffer per cycle and loads a registered output stage
// that hands off with a valid/ready handshake.
//
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset
//   in_data     [N_REQ][N_DATA_BITS] payload per requester
//   in_en       [N_REQ] enqueue strobe per requester
//   in_notFull  [N_REQ] requester i may assert in_en[i] this cycle
//   out_data    granted payload
//   out_idx     index of the requester that produced out_data
//   out_valid   output stage holds an entry
//   out_ready   consumer accepts the entry this cycle
//

// ---------------------------------------------------------------------------
// Per-requester two-slot buffer.
//
// valid[1] is the head (the entry offered to the scheduler), valid[0] is the
// second slot. The second slot is only ever occupied while the head is, so
// the buffer holds 0, 1 or 2 entries with no holes.
//
// not_full is purely a function of registered state, so a producer never
// sees a combinational path from the downstream ready back to its enable.
// The cost is that a full buffer refuses an enqueue even in a cycle where
// it is also dequeued.
// ---------------------------------------------------------------------------
module cci_mpf_prim_rr_fifo2_arb_buf #(
  parameter int N_DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enq_en,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   deq_en,
  output logic                   not_full,
  output logic                   head_valid,
  output logic [N_DATA_BITS-1:0] head_data
);

  logic [1:0]             valid;     // [1] head, [0] second slot
  logic [N_DATA_BITS-1:0] data_head;
  logic [N_DATA_BITS-1:0] data_s0;

  // Held low through reset so producers cannot push into a buffer that is
  // being cleared.
  assign not_full   = reset_n && !valid[0];
  assign head_valid = valid[1];
  assign head_data  = data_head;

  // Valid flags. deq_en is only raised by the scheduler when the head is
  // valid, and enq_en is only legal while the second slot is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 2'b00;
    end else if (deq_en) begin
      // Second slot moves into the head, or a same-cycle enqueue refills it.
      valid[1] <= valid[0] || enq_en;
      valid[0] <= 1'b0;
    end else if (enq_en) begin
      // Fill the head if empty, otherwise stack behind it.
      valid[1] <= 1'b1;
      valid[0] <= valid[1];
    end
  end

  // Payload registers are left unreset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (deq_en) begin
      if (valid[0]) begin
        data_head <= data_s0;
      end else if (enq_en) begin
        data_head <= enq_data;
      end
    end else if (enq_en) begin
      if (valid[1]) begin
        data_s0 <= enq_data;
      end else begin
        data_head <= enq_data;
      end
    end
  end

  // Pushing into a full buffer would silently drop data.
  enq_not_full_a: assert property (@(posedge clk) disable iff (!reset_n)
                                   enq_en |-> !valid[0])
    else $fatal(1, "ENQ to full FIFO");

endmodule


// ---------------------------------------------------------------------------
// Top: buffers, round-robin scheduler and registered output stage.
// ---------------------------------------------------------------------------
module cci_mpf_prim_rr_fifo2_arb #(
  parameter  int N_REQ       = 4,
  parameter  int N_DATA_BITS = 32,
  localparam int N_IDX_BITS  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,

  input  logic [N_REQ-1:0][N_DATA_BITS-1:0] in_data,
  input  logic [N_REQ-1:0]                  in_en,
  output logic [N_REQ-1:0]                  in_notFull,

  output logic [N_DATA_BITS-1:0]            out_data,
  output logic [N_IDX_BITS-1:0]             out_idx,
  output logic                              out_valid,
  input  logic                              out_ready
);

  // Entry held in the output stage.
  typedef struct packed {
    logic [N_IDX_BITS-1:0]  idx;
    logic [N_DATA_BITS-1:0] data;
  } out_entry_t;

  logic [N_REQ-1:0]                  head_valid;
  logic [N_REQ-1:0][N_DATA_BITS-1:0] head_data;
  logic [N_REQ-1:0]                  deq;

  logic [N_IDX_BITS-1:0] ptr;        // highest-priority requester this cycle
  logic [N_IDX_BITS-1:0] ptr_nxt;
  logic [N_IDX_BITS-1:0] winner;
  logic                  win_valid;
  logic                  advance;    // output stage can take a new entry

  out_entry_t out_q;
  logic       out_vld_q;

  // -------------------------------------------------------------------------
  // Per-requester buffers
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    cci_mpf_prim_rr_fifo2_arb_buf #(
      .N_DATA_BITS (N_DATA_BITS)
    ) buf_i (
      .clk        (clk),
      .reset_n    (reset_n),
      .enq_en     (in_en[i]),
      .enq_data   (in_data[i]),
      .deq_en     (deq[i]),
      .not_full   (in_notFull[i]),
      .head_valid (head_valid[i]),
      .head_data  (head_data[i])
    );

    // Only the winner is popped, and only when the output stage moves.
    assign deq[i] = advance && win_valid && (winner == N_IDX_BITS'(i));
  end

  // -------------------------------------------------------------------------
  // Scheduler
  // -------------------------------------------------------------------------
  // A full output stage that is not being drained freezes everything:
  // no pop, and ptr/out_* hold their values.
  assign advance = !out_vld_q || out_ready;

  // Scan ptr, ptr+1, ... wrapping at N_REQ; the first valid head wins.
  // N_REQ need not be a power of two, so the wrap is explicit.
  always_comb begin
    int                    j;
    logic [N_IDX_BITS-1:0] cand;
    win_valid = 1'b0;
    winner    = '0;
    j         = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = N_IDX_BITS'(j);
      if (!win_valid && head_valid[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Priority moves to the requester just after the winner, which gives each
  // of K continuously busy requesters one grant in every K grants. With a
  // single requester this is constant 0.
  assign ptr_nxt = (winner == N_IDX_BITS'(N_REQ - 1)) ? '0
                                                      : winner + 1'b1;

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q <= 1'b0;
      ptr       <= '0;
    end else if (advance) begin
      // With nothing to send the stage empties and ptr stays put, so an idle
      // cycle never shifts priority.
      out_vld_q <= win_valid;
      if (win_valid) ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && win_valid) begin
      out_q.data <= head_data[winner];
      out_q.idx  <= winner;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_q.data;
  assign out_idx   = out_q.idx;

endmodule

// File: doc/cci_mpf_prim_rr_fifo2_arb.md
Name: cci_mpf_prim_rr_fifo2_arb

Overview:
- Merges N_REQ independent producer channels onto one shared output stream.
- Each requester has a private two-entry, fully pipelined buffer. Buffer state is valid flags per slot; slot 1 is the head.
- A round-robin scheduler picks one non-empty buffer per cycle and loads a registered output stage with valid/ready handshake.
- Used wherever several MPF pipelines share one downstream request or response channel.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- N_DATA_BITS, 32, payload width per entry.
- N_IDX_BITS, derived: max(1, clog2(N_REQ)). Localparam, not overridable.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  N_REQ x N_DATA_BITS  payload per requester
- in_en  in  N_REQ  enqueue strobe per requester
- in_notFull  out  N_REQ  requester i may assert in_en[i] this cycle
- out_data  out  N_DATA_BITS  granted payload
- out_idx  out  N_IDX_BITS  requester index that produced out_data
- out_valid  out  1  output stage holds an entry
- out_ready  in  1  consumer accepts the entry this cycle

Behaviour:
- Reset (reset_n low, asynchronous assert):
  - All buffer valid flags cleared; out_valid=0; round-robin pointer ptr=0.
  - in_notFull forced 0 while reset_n is low.
  - Data registers are not reset.
  - Reset mid-operation discards all buffered and output entries. No partial transfer survives.
- Buffers, per requester i (two-slot semantics):
  - in_notFull[i] = slot 0 empty. It depends only on registered state, never on in_en or out_ready.
  - Enqueue into an empty head: head valid next cycle.
  - Enqueue while the head is valid and not dequeued: goes to slot 0.
  - On dequeue, slot 0 shifts to the head, or a same-cycle enqueue lands in the head.
  - A buffer holding 2 entries refuses enqueue even if dequeued that cycle (in_notFull already 0).
  - in_en[i] while in_notFull[i]=0 is illegal. Simulation assertion: $fatal "ENQ to full FIFO".
- Scheduler:
  - advance = !out_valid || out_ready.
  - When advance: winner = first i with a valid head, scanning ptr, ptr+1, ... modulo N_REQ.
  - Winner's head is dequeued this cycle.
  - Next edge: out_data <= head data, out_idx <= winner, out_valid <= 1, ptr <= (winner+1) mod N_REQ.
  - No valid head while advancing: out_valid <= 0, ptr unchanged.
  - Not advancing (out_valid && !out_ready): no dequeue; out_data, out_idx and ptr held stable.
- Timing:
  - Latency: in_en[i] in cycle c with empty buffer and free output gives out_valid in cycle c+2.
  - Sustained throughput is one entry per cycle total.
  - A single active requester can stream one per cycle with in_notFull staying 1.
- Fairness: with K requesters continuously non-empty, each is granted exactly once in every K consecutive grants.
- N_REQ=1: ptr is constant 0; out_idx is always 0; behaves as a fifo2 followed by an output register.
- Assertion: out_ready is ignored when out_valid=0. No error is raised.

Test Plan:
- Reset: hold reset_n=0 with in_en=4'b1111 -> in_notFull=0 and out_valid=0. After release, in_notFull=4'b1111 and no output for 3 cycles.
- Single stream: requester 2 enqueues 0x10..0x17 on consecutive cycles, out_ready=1 -> out_data 0x10..0x17 in order, out_idx=2, first out_valid 2 cycles after first in_en, no bubbles, in_notFull[2] stays 1.
- Round-robin: preload each requester with 2 entries (r*0x100+k), then out_ready=1 -> out_idx sequence 0,1,2,3,0,1,2,3 with matching data.
- Backpressure: out_ready=0 for 5 cycles with all buffers full -> out_data and out_idx stable, in_notFull=4'b0000, no entries lost. Raise out_ready -> all 8 entries drain in fair order.
- Pointer skip: only requesters 1 and 3 active, ptr=2 -> grants 3,1,3,1. Idle cycle with no requests -> ptr unchanged.
- Mid-stream reset: assert reset_n=0 asynchronously while out_valid=1 and buffers are partially full -> out_valid drops immediately. After release, only newly enqueued data appears and the first grant goes to index 0.
